data_register_bank: RTL and testbench
=====================================

# data_register_bank

Test-data-register bank of the JTAG block, directly downstream of the instruction register. It consumes the one-hot decoded instruction vector and the DR-phase strobes from the TAP controller. It holds the bypass, IDCODE and boundary-scan registers, selects the active one, and drives the retimed TDO/TDO-enable for the whole TAP, muxing in the instruction register's serial output during Shift-IR.

## Interface
- BSR_WIDTH, default 8: number of boundary-scan cells, minimum 1.
- IDCODE_VALUE, default 32'h1234_5679: device ID; bit 0 must be 1 (IEEE 1149.1).
- tck  in  1  test clock; all flops are posedge except the TDO stage.
- tl_reset  in  1  reset: asynchronous, active-low.
- tdi  in  1  serial data in.
- captureDR / shiftDR / updateDR  in  1 each  TAP state strobes, sampled at posedge tck.
- shiftIR  in  1  TAP is in Shift-IR.
- ir_tdo  in  1  instruction register serial out.
- instructions  in  INST_COUNT  one-hot latched instruction (`D_*` encodings).
- sys_in  in  BSR_WIDTH  functional core-side signals.
- sys_out  out  BSR_WIDTH  pad-side signals.
- core_reset_n  out  1  core reset request, active-low.
- tdo  out  1  serial out, changes on negedge tck.
- tdo_en  out  1  TDO output enable.

## Operation
- Register selection:
  - IDCODE selects the 32-bit ID register.
  - SAMPLE_PRELOAD and EXTEST select the BSR.
  - BYPASS, CLAMP, IC_RESET and all-zero/illegal vectors select the 1-bit bypass register.
  - Unselected registers hold their value.
- Bypass register:
  - captureDR loads 0.
  - shiftDR loads tdi.
- ID register:
  - captureDR loads IDCODE_VALUE.
  - shiftDR shifts right: tdi enters bit 31, bit 0 is the serial out.
- BSR shift stage:
  - captureDR loads sys_in.
  - shiftDR shifts right: tdi enters bit BSR_WIDTH-1, bit 0 is the serial out.
- BSR update latch: updateDR copies the shift stage into a parallel latch, regardless of the current instruction.
- sys_out:
  - Equals the update latch when EXTEST or CLAMP is active.
  - Otherwise equals sys_in (combinational pass-through).
- core_reset_n: low exactly while IC_RESET is the active instruction; high otherwise.
- TDO source:
  - ir_tdo when shiftIR is high.
  - Otherwise the serial out of the selected DR.
- Simultaneous strobes: captureDR has priority over shiftDR, and shiftDR over updateDR. The TAP never asserts these together; the priority is defined so behaviour is deterministic.
- Reset (tl_reset low, asynchronous, any time including mid-shift):
  - Bypass = 0, ID shift = IDCODE_VALUE, BSR shift = 0, update latch = 0.
  - tdo = 0, tdo_en = 0.
  - sys_out follows sys_in; with tl_reset low the instruction register forces IDCODE.

## Timing
- Capture: value is present in the selected register after the posedge tck with captureDR = 1.
- TDO: the negedge-tck flop samples the mux, so bit 0 appears on tdo half a cycle after capture. Each shift posedge is reflected at the following negedge.
- tdo_en: registered at negedge tck as shiftIR | shiftDR. It is high from the first negedge in a shift state until the first negedge after leaving it.
- Bypass latency: tdi to tdo is 1 tck of shift.
- IDCODE latency: tdi reaches tdo after 32 shifts.
- BSR latency: tdi reaches tdo after BSR_WIDTH shifts.
- sys_out: changes combinationally after the update-latch posedge, or whenever instructions changes.

## Structure
- `D_*` one-hot encodings and INST_COUNT come from the shared defines package.
- Add the IDCODE default and a BSR cell-count constant to the shared defines package.
- The boundary-scan cell (capture/shift flop + update latch + output mux) is a natural sub-module: `boundary_scan_cell`, instantiated BSR_WIDTH times in a generate loop.
- Bypass, ID register, select logic and the TDO stage stay in this module.

## Test plan
- **IDCODE readout**: reset, then capture and shift 32 cycles with tdi = 0.
  - tdo LSB-first = 32'h1234_5679.
  - tdo_en high only during shift.
- **BYPASS**: capture, then shift tdi pattern 1,0,1,1.
  - tdo = 0 (captured), then 1,0,1 delayed by one cycle.
- **SAMPLE_PRELOAD**: sys_in = 8'hA5; capture, then shift 8 with tdi pattern 8'h3C; update; then switch to EXTEST.
  - tdo = A5 LSB-first.
  - sys_out stays A5 until EXTEST is active, then = 3C.
- **CLAMP after preload of 8'hF0**: sys_out = F0 while sys_in toggles; tdo shows bypass behaviour.
- **Reset mid-shift**: assert tl_reset after 10 IDCODE shifts.
  - Immediately: tdo = 0, tdo_en = 0, update latch = 0.
  - Next capture reads the full IDCODE again.
- **IR passthrough and IC_RESET**:
  - shiftIR = 1 with ir_tdo toggling: tdo follows ir_tdo one negedge later.
  - IC_RESET active: core_reset_n = 0.

Source files
------------

// File: rtl/data_register_bank_pkg.sv
// Shared JTAG defines: one-hot instruction encodings, data-register selection type and defaults.
package data_register_bank_pkg;

    localparam int INST_COUNT = 6;

    localparam logic [INST_COUNT-1:0] D_EXTEST         = 6'b000001;
    localparam logic [INST_COUNT-1:0] D_SAMPLE_PRELOAD = 6'b000010;
    localparam logic [INST_COUNT-1:0] D_IDCODE         = 6'b000100;
    localparam logic [INST_COUNT-1:0] D_BYPASS         = 6'b001000;
    localparam logic [INST_COUNT-1:0] D_CLAMP          = 6'b010000;
    localparam logic [INST_COUNT-1:0] D_IC_RESET       = 6'b100000;

    // Bit 0 must stay 1 so a scan chain can tell an IDCODE from a bypass bit.
    localparam logic [31:0] IDCODE_DEFAULT = 32'h1234_5679;
    localparam int          BSR_CELLS      = 8;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_BSR    = 2'd2
    } dr_sel_e;

    // Anything that is not a recognised IDCODE/BSR instruction falls back to bypass.
    function automatic dr_sel_e dr_select(input logic [INST_COUNT-1:0] inst);
        if (inst == D_IDCODE)
            return SEL_IDCODE;
        else if ((inst == D_SAMPLE_PRELOAD) || (inst == D_EXTEST))
            return SEL_BSR;
        else
            return SEL_BYPASS;
    endfunction

endpackage

// File: rtl/data_register_bank_boundary_scan_cell.sv
// One boundary-scan cell: capture/shift flop, parallel update flop and pad-side output mux.
module boundary_scan_cell (
    input  logic tck,
    input  logic tl_reset,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic mode,
    input  logic si,
    input  logic pi,
    output logic so,
    output logic po
);

    logic upd_q;

    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset)
            so <= 1'b0;
        else if (capture)
            so <= pi;
        else if (shift)
            so <= si;
    end

    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset)
            upd_q <= 1'b0;
        else if (update)
            upd_q <= so;
    end

    assign po = mode ? upd_q : pi;

endmodule

// File: rtl/data_register_bank.sv
// JTAG test-data-register bank: bypass, IDCODE and boundary-scan registers plus the
// negedge-retimed TDO/TDO-enable stage shared by the whole TAP.
module data_register_bank
    import data_register_bank_pkg::*;
#(
    parameter int          BSR_WIDTH    = BSR_CELLS,
    parameter logic [31:0] IDCODE_VALUE = IDCODE_DEFAULT
) (
    input  logic                  tck,
    input  logic                  tl_reset,
    input  logic                  tdi,
    input  logic                  captureDR,
    input  logic                  shiftDR,
    input  logic                  updateDR,
    input  logic                  shiftIR,
    input  logic                  ir_tdo,
    input  logic [INST_COUNT-1:0] instructions,
    input  logic [BSR_WIDTH-1:0]  sys_in,
    output logic [BSR_WIDTH-1:0]  sys_out,
    output logic                  core_reset_n,
    output logic                  tdo,
    output logic                  tdo_en
);

    dr_sel_e              dr_sel;
    logic                 bypass_q;
    logic [31:0]          id_q;
    logic [BSR_WIDTH-1:0] bsr_so;
    logic [BSR_WIDTH-1:0] bsr_si;
    logic                 bsr_capture;
    logic                 bsr_shift;
    logic                 bsr_update;
    logic                 drive_latch;
    logic                 dr_so;
    logic                 tdo_mux;

    assign dr_sel = dr_select(instructions);

    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset)
            bypass_q <= 1'b0;
        else if (dr_sel == SEL_BYPASS) begin
            if (captureDR)
                bypass_q <= 1'b0;
            else if (shiftDR)
                bypass_q <= tdi;
        end
    end

    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset)
            id_q <= IDCODE_VALUE;
        else if (dr_sel == SEL_IDCODE) begin
            if (captureDR)
                id_q <= IDCODE_VALUE;
            else if (shiftDR)
                id_q <= {tdi, id_q[31:1]};
        end
    end

    // Update ignores the instruction but yields to any capture/shift strobe in the same cycle.
    assign bsr_capture = captureDR && (dr_sel == SEL_BSR);
    assign bsr_shift   = shiftDR && (dr_sel == SEL_BSR);
    assign bsr_update  = updateDR && !captureDR && !shiftDR;
    assign drive_latch = (instructions == D_EXTEST) || (instructions == D_CLAMP);

    for (genvar i = 0; i < BSR_WIDTH; i++) begin : g_bsr
        if (i == BSR_WIDTH - 1) begin : g_head
            assign bsr_si[i] = tdi;
        end else begin : g_body
            assign bsr_si[i] = bsr_so[i+1];
        end

        boundary_scan_cell u_cell (
            .tck      (tck),
            .tl_reset (tl_reset),
            .capture  (bsr_capture),
            .shift    (bsr_shift),
            .update   (bsr_update),
            .mode     (drive_latch),
            .si       (bsr_si[i]),
            .pi       (sys_in[i]),
            .so       (bsr_so[i]),
            .po       (sys_out[i])
        );
    end

    assign core_reset_n = (instructions != D_IC_RESET);

    always_comb begin
        dr_so = bypass_q;
        case (dr_sel)
            SEL_IDCODE: dr_so = id_q[0];
            SEL_BSR:    dr_so = bsr_so[0];
            default:    dr_so = bypass_q;
        endcase
    end

    assign tdo_mux = shiftIR ? ir_tdo : dr_so;

    // TDO stage: retimed on the falling edge so the pin is stable around the next rising edge.
    always_ff @(negedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= tdo_mux;
            tdo_en <= shiftIR | shiftDR;
        end
    end

endmodule

// File: tb/tb_data_register_bank.sv
// Directed and randomized bench for data_register_bank against a behavioural register model.
module tb_data_register_bank;
    import data_register_bank_pkg::*;

    localparam int          W  = 8;
    localparam logic [31:0] ID = 32'h1234_5679;

    logic                  tck = 1'b0;
    logic                  tl_reset;
    logic                  tdi;
    logic                  captureDR;
    logic                  shiftDR;
    logic                  updateDR;
    logic                  shiftIR;
    logic                  ir_tdo;
    logic [INST_COUNT-1:0] instructions;
    logic [W-1:0]          sys_in;
    logic [W-1:0]          sys_out;
    logic                  core_reset_n;
    logic                  tdo;
    logic                  tdo_en;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the register contents.
    logic         m_byp;
    logic [31:0]  m_id;
    logic [W-1:0] m_bsr;
    logic [W-1:0] m_lat;

    logic [INST_COUNT-1:0] inst_pool [8];

    data_register_bank #(.BSR_WIDTH(W), .IDCODE_VALUE(ID)) dut (
        .tck          (tck),
        .tl_reset     (tl_reset),
        .tdi          (tdi),
        .captureDR    (captureDR),
        .shiftDR      (shiftDR),
        .updateDR     (updateDR),
        .shiftIR      (shiftIR),
        .ir_tdo       (ir_tdo),
        .instructions (instructions),
        .sys_in       (sys_in),
        .sys_out      (sys_out),
        .core_reset_n (core_reset_n),
        .tdo          (tdo),
        .tdo_en       (tdo_en)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = bypass, 1 = IDCODE, 2 = boundary scan
    function automatic int which_dr(input logic [INST_COUNT-1:0] v);
        if (v == D_IDCODE) return 1;
        if (v == D_SAMPLE_PRELOAD || v == D_EXTEST) return 2;
        return 0;
    endfunction

    function automatic logic model_lsb();
        case (which_dr(instructions))
            1:       return m_id[0];
            2:       return m_bsr[0];
            default: return m_byp;
        endcase
    endfunction

    function automatic logic [W-1:0] model_sys_out();
        if (instructions == D_EXTEST || instructions == D_CLAMP) return m_lat;
        return sys_in;
    endfunction

    task automatic model_reset();
        m_byp = 1'b0;
        m_id  = ID;
        m_bsr = '0;
        m_lat = '0;
    endtask

    task automatic model_posedge(input logic cap, input logic sh, input logic upd, input logic din);
        int d;
        d = which_dr(instructions);
        if (cap) begin
            if (d == 1)      m_id  = ID;
            else if (d == 2) m_bsr = sys_in;
            else             m_byp = 1'b0;
        end else if (sh) begin
            if (d == 1)      m_id  = (m_id >> 1) | (32'(din) << 31);
            else if (d == 2) m_bsr = (m_bsr >> 1) | (W'(din) << (W - 1));
            else             m_byp = din;
        end else if (upd) begin
            m_lat = m_bsr;
        end
    endtask

    // Called at negedge+1; leaves the bench at the following negedge+1.
    task automatic run_cycle(input logic cap, input logic sh, input logic upd,
                             input logic sir, input logic din, input logic irt);
        logic exp_tdo;
        captureDR = cap;
        shiftDR   = sh;
        updateDR  = upd;
        shiftIR   = sir;
        tdi       = din;
        ir_tdo    = irt;
        @(posedge tck);
        model_posedge(cap, sh, upd, din);
        #1;
        check("sys_out", 32'(sys_out), 32'(model_sys_out()));
        check("core_reset_n", 32'(core_reset_n), 32'(instructions != D_IC_RESET));
        exp_tdo = sir ? irt : model_lsb();
        @(negedge tck);
        #1;
        check("tdo", 32'(tdo), 32'(exp_tdo));
        check("tdo_en", 32'(tdo_en), 32'(sir | sh));
    endtask

    // Capture, then n shifts; word collects the n bits that leave on tdo.
    task automatic scan_dr(input int n, input logic [31:0] tdi_bits, output logic [31:0] word);
        word = '0;
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        word[0] = tdo;
        for (int i = 0; i < n; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'b0, tdi_bits[i], 1'b0);
            if (i < n - 1) word[i+1] = tdo;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        logic [31:0] word;
        logic [4:0]  byp_bits;
        int          r;

        inst_pool[0] = D_EXTEST;
        inst_pool[1] = D_SAMPLE_PRELOAD;
        inst_pool[2] = D_IDCODE;
        inst_pool[3] = D_BYPASS;
        inst_pool[4] = D_CLAMP;
        inst_pool[5] = D_IC_RESET;
        inst_pool[6] = '0;
        inst_pool[7] = 6'b000011;

        tl_reset     = 1'b0;
        tdi          = 1'b0;
        captureDR    = 1'b0;
        shiftDR      = 1'b0;
        updateDR     = 1'b0;
        shiftIR      = 1'b0;
        ir_tdo       = 1'b0;
        instructions = D_IDCODE;
        sys_in       = W'($urandom);
        model_reset();
        #2;
        check("reset_tdo", 32'(tdo), 32'd0);
        check("reset_tdo_en", 32'(tdo_en), 32'd0);
        check("reset_sys_out", 32'(sys_out), 32'(sys_in));
        check("reset_core_reset_n", 32'(core_reset_n), 32'd1);
        @(negedge tck);
        #1;
        tl_reset = 1'b1;

        // IDCODE readout
        scan_dr(32, 32'h0, word);
        check("idcode_word", word, 32'h1234_5679);
        idle(1);

        // BYPASS with 1,0,1,1
        instructions = D_BYPASS;
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        byp_bits[0] = tdo;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); byp_bits[1] = tdo;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); byp_bits[2] = tdo;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); byp_bits[3] = tdo;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); byp_bits[4] = tdo;
        check("bypass_bits", 32'(byp_bits), 32'(5'b11010));
        idle(1);

        // SAMPLE_PRELOAD A5 out, 3C in, then EXTEST
        instructions = D_SAMPLE_PRELOAD;
        sys_in       = 8'hA5;
        scan_dr(W, 32'h3C, word);
        check("sample_word", word, 32'hA5);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("preload_sys_out_held", 32'(sys_out), 32'hA5);
        instructions = D_EXTEST;
        #1;
        check("extest_sys_out", 32'(sys_out), 32'h3C);
        idle(2);

        // CLAMP after preload of F0
        instructions = D_SAMPLE_PRELOAD;
        scan_dr(W, 32'hF0, word);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        instructions = D_CLAMP;
        for (int i = 0; i < 6; i++) begin
            sys_in = ~sys_in;
            #1;
            check("clamp_sys_out", 32'(sys_out), 32'hF0);
            run_cycle(i == 0, i != 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        // IR passthrough and IC_RESET
        instructions = D_IC_RESET;
        for (int i = 0; i < 6; i++)
            run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'(i % 2));
        check("ic_reset_core_reset_n", 32'(core_reset_n), 32'd0);
        idle(1);

        // Randomized traffic, including illegal vectors and stacked strobes
        for (int n = 0; n < 300; n++) begin
            if (n % 7 == 0) instructions = inst_pool[$urandom_range(0, 7)];
            sys_in = W'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 1)
                run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
            else if (r <= 5)
                run_cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
            else if (r == 6)
                run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom));
            else if (r == 7)
                run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
            else
                run_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
        end

        // Load FF into the update latch, then reset in the middle of an IDCODE shift
        instructions = D_SAMPLE_PRELOAD;
        scan_dr(W, 32'hFF, word);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        instructions = D_IDCODE;
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        shiftDR = 1'b1;
        #2;
        tl_reset = 1'b0;
        model_reset();
        #1;
        check("midshift_reset_tdo", 32'(tdo), 32'd0);
        check("midshift_reset_tdo_en", 32'(tdo_en), 32'd0);
        check("midshift_reset_sys_out", 32'(sys_out), 32'(sys_in));
        @(posedge tck);
        @(negedge tck);
        #1;
        check("reset_hold_tdo_en", 32'(tdo_en), 32'd0);
        shiftDR  = 1'b0;
        tl_reset = 1'b1;
        instructions = D_EXTEST;
        #1;
        check("reset_latch_cleared", 32'(sys_out), 32'h0);
        instructions = D_IDCODE;
        scan_dr(32, 32'h0, word);
        check("idcode_after_reset", word, 32'h1234_5679);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
